// File: rtl/restoring_div_pkg.sv
// Shared types and helpers for the parametrised restoring divider.
// Helpers work on MAXW-bit values; callers size-cast in and out.
package restoring_div_pkg;

  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [MAXW-1:0] cond_neg(
    input logic [MAXW-1:0] x,
    input logic            neg
  );
    return neg ? (~x + MAXW'(1)) : x;
  endfunction

  function automatic logic [MAXW-1:0] abs_val(
    input logic [MAXW-1:0] x,
    input logic            msb,
    input logic            sgn
  );
    return cond_neg(x, sgn & msb);
  endfunction

endpackage

// File: rtl/restoring_divider_param_datapath.sv
// Operand registers, shift/subtract/restore step, iteration counter
// and sign fix-up for restoring_divider_param.
module restoring_div_datapath
  import restoring_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             zload,
  input  logic             step,
  input  logic             fix,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             cnt_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH:0]   r_q;
  logic [CW-1:0]    cnt_q;
  logic             negq_q;
  logic             negr_q;
  logic             zero_q;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dsr_abs;
  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] trial;
  logic             lt;

  assign dvd_abs = WIDTH'(abs_val(MAXW'(dividend),
                   dividend[WIDTH-1], is_signed));
  assign dsr_abs = WIDTH'(abs_val(MAXW'(divisor),
                   divisor[WIDTH-1], is_signed));

  // Trial subtract one bit wider than the partial remainder to expose the borrow.
  assign r_sh  = {r_q, q_q[WIDTH-1]};
  assign trial = r_sh - {2'b00, d_q};
  assign lt    = trial[WIDTH+1];

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q       <= '0;
      q_q       <= '0;
      dvd_q     <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      zero_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (load) begin
        d_q    <= dsr_abs;
        q_q    <= dvd_abs;
        dvd_q  <= dividend;
        r_q    <= '0;
        cnt_q  <= CW'(WIDTH);
        negq_q <= is_signed &
                  (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        negr_q <= is_signed & dividend[WIDTH-1];
        zero_q <= (divisor == '0);
      end
      if (zload) begin
        quotient  <= '1;
        remainder <= dividend;
      end
      if (step) begin
        r_q   <= lt ? r_sh[WIDTH:0] : trial[WIDTH:0];
        q_q   <= {q_q[WIDTH-2:0], ~lt};
        cnt_q <= cnt_q - CW'(1);
      end
      if (fix) begin
        quotient  <= zero_q ? '1 :
                     WIDTH'(cond_neg(MAXW'(q_q), negq_q));
        remainder <= zero_q ? dvd_q :
                     WIDTH'(cond_neg(MAXW'(r_q[WIDTH-1:0]), negr_q));
      end
    end
  end

endmodule

// File: rtl/restoring_divider_param.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready ports.
// Define RESTORING_DIV_ZERO_DETECT_EN for a one-cycle divide-by-zero path.
module restoring_divider_param
  import restoring_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             dest_valid,
  input  logic             dest_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_e state_q;
  logic   accept;
  logic   load;
  logic   zload;
  logic   step;
  logic   fix;
  logic   cnt_zero;

  assign src_ready  = (state_q == IDLE);
  assign dest_valid = (state_q == DONE);
  assign accept     = src_valid & src_ready;

`ifdef RESTORING_DIV_ZERO_DETECT_EN
  logic dbz_q;

  assign zload = accept & (divisor == '0);

  always_ff @(posedge clk) begin
    if (rst)
      dbz_q <= 1'b0;
    else if (accept)
      dbz_q <= (divisor == '0);
  end

  assign div_by_zero = dbz_q;
`else
  assign zload       = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  assign load = accept & ~zload;
  assign step = (state_q == CALC) & ~cnt_zero;
  assign fix  = (state_q == SIGN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) state_q <= zload ? DONE : CALC;
        CALC: if (cnt_zero) state_q <= SIGN;
        SIGN: state_q <= DONE;
        DONE: if (dest_ready) state_q <= IDLE;
      endcase
    end
  end

  restoring_div_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .zload    (zload),
    .step     (step),
    .fix      (fix),
    .is_signed(is_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .cnt_zero (cnt_zero),
    .quotient (quotient),
    .remainder(remainder)
  );

endmodule
